// File: rtl/mm_skew_feeder_pkg.sv
// mm_skew_feeder_pkg
// Shared definitions for the systolic-array operand feeder:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - operand matrix select encoding
//   - default array geometry
//   - wavefront count and diagonal-band helpers
package mm_skew_feeder_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 3'd0;
    localparam fsm_state_t ST_CLR  = 3'd1;
    localparam fsm_state_t ST_LOAD = 3'd2;
    localparam fsm_state_t ST_WAIT = 3'd3;
    localparam fsm_state_t ST_FIN  = 3'd4;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } mat_sel_e;

    localparam int DEF_N  = 2;
    localparam int DEF_DW = 2;

    // Number of skewed wavefronts needed to push an NxN product through
    // an NxN array: the last element enters PE[N-1][N-1] at t = 3N-3.
    function automatic int wave_count(input int n);
        return 3 * n - 2;
    endfunction

    // True when lane idx carries a real matrix element on wavefront t,
    // i.e. the diagonal offset t-idx lies inside the matrix.
    function automatic logic in_band(input int t, input int idx, input int n);
        return ((t - idx) >= 0) && ((t - idx) < n);
    endfunction

endpackage

// File: rtl/mm_skew_feeder_if.sv
// mm_skew_feeder_if
// Bundles the operand write port, job control, PE handshake and the
// skewed edge feeds of the systolic array feeder.
//   master : operand writer / array integrator side (drives writes,
//            start and done_pe_in; observes feeds and status)
//   slave  : the feeder itself
// Signals:
//   wr_en, wr_sel, wr_row, wr_col, wr_data : operand element write
//   start       : begin a job
//   done_pe_in  : done_pe of PE[i][j] at bit i*N+j
//   acc_clr     : one-cycle accumulator clear pulse
//   load_out    : one-cycle load pulse per wavefront
//   row_feed    : row_in of PE[i][0] at [i*DW +: DW]
//   col_feed    : col_in of PE[0][j] at [j*DW +: DW]
//   busy, done, timeout_err : job status
interface mm_skew_feeder_if #(
    parameter int N  = 2,
    parameter int DW = 2,
    parameter int AW = 1
);
    logic              wr_en;
    logic              wr_sel;
    logic [AW-1:0]     wr_row;
    logic [AW-1:0]     wr_col;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic [N*N-1:0]    done_pe_in;
    logic              acc_clr;
    logic              load_out;
    logic [N*DW-1:0]   row_feed;
    logic [N*DW-1:0]   col_feed;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start, done_pe_in,
        input  acc_clr, load_out, row_feed, col_feed, busy, done, timeout_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, done_pe_in,
        output acc_clr, load_out, row_feed, col_feed, busy, done, timeout_err
    );
endinterface

// File: rtl/mm_skew_feeder_done_collector.sv
// mm_done_collector
// Sticky OR of the per-PE done flags for the current wavefront. PEs may
// report done in any order and need not hold the flag; once every bit has
// been seen, all_done rises. all_done includes the current-cycle flags so
// the feeder can advance in the same cycle the last PE reports.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear the mask (new wavefront issued)
//   en        : accumulate done_in this cycle
//   done_in   : per-PE done flags
//   all_done  : every PE has reported since the last clear (only while en)
module mm_done_collector #(
    parameter int NB = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [NB-1:0] done_in,
    output logic          all_done
);

    logic [NB-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mask_q <= '0;
        end else if (en) begin
            mask_q <= mask_q | done_in;
        end
    end

    assign all_done = en && (&(mask_q | done_in));

endmodule

// File: rtl/mm_skew_feeder.sv
// mm_skew_feeder
// Upstream stage of the NxN systolic matrix multiplier. Stores operand
// matrices A and B, then drives the array's west edge (row_feed) and
// north edge (col_feed) with diagonally skewed wavefronts. Each wavefront
// is announced with a one-cycle load_out pulse; the next one is issued
// only after every PE has reported done_pe. acc_clr pulses once at job
// start to clear the PE accumulators.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mm_skew_feeder_if.slave (write port, start, done_pe_in,
//          acc_clr, load_out, row_feed, col_feed, busy, done, timeout_err)
// Configuration:
//   FEED_TIMEOUT_EN : when defined, a per-wavefront watchdog aborts the
//                     job after TMO cycles in WAIT without a full done mask
//                     and sets the sticky timeout_err flag. When undefined,
//                     WAIT has no bound and timeout_err is tied low.
module mm_skew_feeder
    import mm_skew_feeder_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int DW  = DEF_DW,
    parameter int AW  = (N > 1) ? $clog2(N) : 1,
    parameter int TMO = 64
) (
    input  logic           clk,
    input  logic           rst,
    mm_skew_feeder_if.slave bus
);

    localparam int W  = wave_count(N);
    localparam int TW = $clog2(W + 1);

    if (N < 1 || TMO < 1) begin : g_param_chk
        $error("mm_skew_feeder: N and TMO must be at least 1");
    end

    logic [DW-1:0]   a_mem [N][N];
    logic [DW-1:0]   b_mem [N][N];

    fsm_state_t      state;
    fsm_state_t      state_nxt;
    logic [TW-1:0]   wave_t;
    logic [TW-1:0]   load_t;
    logic [N*DW-1:0] row_nxt;
    logic [N*DW-1:0] col_nxt;
    logic [N*DW-1:0] row_p0;
    logic [N*DW-1:0] col_p0;
    logic            all_done;
    logic            wr_ok;
    logic            wd_fire;

    // Column/row offset of the element lane i carries on wavefront t.
    function automatic logic [AW-1:0] lane_idx(input logic [TW-1:0] t, input int i);
        int k;
        k = int'(t) - i;
        return k[AW-1:0];
    endfunction

    // Operand storage: writable only while idle, so a running job always
    // sees a consistent matrix pair.
    assign wr_ok = bus.wr_en && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (mat_sel_e'(bus.wr_sel) == SEL_B) begin
                b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end else begin
                a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end
        end
    end

    // Wavefront about to be issued: 0 when leaving CLR, otherwise the next
    // index after the one currently in flight.
    always_comb begin
        load_t  = (state == ST_CLR) ? '0 : wave_t + TW'(1);
        row_nxt = '0;
        col_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (in_band(int'(load_t), i, N)) begin
                row_nxt[i*DW +: DW] = a_mem[i][lane_idx(load_t, i)];
                col_nxt[i*DW +: DW] = b_mem[lane_idx(load_t, i)][i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_CLR;
            ST_CLR:  state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (all_done) begin
                    state_nxt = (wave_t == TW'(W - 1)) ? ST_FIN : ST_LOAD;
                end else if (wd_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: feed registers, loaded together with the LOAD entry and
    // held unchanged through WAIT; zeroed whenever the job ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wave_t <= '0;
            row_p0 <= '0;
            col_p0 <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_LOAD) begin
                wave_t <= load_t;
                row_p0 <= row_nxt;
                col_p0 <= col_nxt;
            end else if (state_nxt == ST_IDLE) begin
                wave_t <= '0;
                row_p0 <= '0;
                col_p0 <= '0;
            end
        end
    end

    // Flags raised during LOAD belong to the previous wavefront (PEs drop
    // done_pe on load), so the mask is cleared there and only collects in WAIT.
    mm_done_collector #(
        .NB (N * N)
    ) u_done_collector (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_LOAD),
        .en       (state == ST_WAIT),
        .done_in  (bus.done_pe_in),
        .all_done (all_done)
    );

`ifdef FEED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] wd_cnt;
    logic          to_err;

    assign wd_fire = (state == ST_WAIT) && !all_done && (wd_cnt == CW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            wd_cnt <= (state == ST_WAIT) ? wd_cnt + CW'(1) : '0;
            if (wd_fire) begin
                to_err <= 1'b1;
            end else if (state == ST_IDLE && bus.start) begin
                to_err <= 1'b0;
            end
        end
    end

    assign bus.timeout_err = to_err;
`else
    assign wd_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.acc_clr  = (state == ST_CLR);
    assign bus.load_out = (state == ST_LOAD);
    assign bus.done     = (state == ST_FIN);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.row_feed = row_p0;
    assign bus.col_feed = col_p0;

endmodule

// File: tb/tb_mm_skew_feeder.sv
// tb_mm_skew_feeder
// Directed bench for mm_skew_feeder (N=2, DW=2, TMO=8). A behavioural
// 2x2 systolic PE array driven by the feeder outputs accumulates C = A*B.
// PE done flags are returned as one-cycle pulses at a programmable delay
// per PE after each load.
module tb_mm_skew_feeder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mm_skew_feeder_if #(.N(2), .DW(2), .AW(1)) bus ();

    mm_skew_feeder #(.N(2), .DW(2), .AW(1), .TMO(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // per-job observations
    int         loads, dones, acc_clrs, lat, min_gap, stable_bad, expired;
    logic [3:0] rowlog [4];
    logic [3:0] collog [4];
    int         acc [2][2];
    int         ar  [2][2];
    int         br  [2][2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 1'(r);
        bus.wr_col  = 1'(c);
        bus.wr_data = 2'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_ab();
        wr(1'b0, 0, 0, 1); wr(1'b0, 0, 1, 2); wr(1'b0, 1, 0, 3); wr(1'b0, 1, 1, 0);
        wr(1'b1, 0, 0, 2); wr(1'b1, 0, 1, 1); wr(1'b1, 1, 0, 1); wr(1'b1, 1, 1, 3);
    endtask

    task automatic check_c(input string tag, input int c00, input int c01, input int c10, input int c11);
        chk({tag, "_c00"}, acc[0][0], c00);
        chk({tag, "_c01"}, acc[0][1], c01);
        chk({tag, "_c10"}, acc[1][0], c10);
        chk({tag, "_c11"}, acc[1][1], c11);
    endtask

    // Runs one job. d0..d3: done_pe pulse delay per PE after each load.
    // poke_at: cycle at which start + write A[0][0]=3 is pulsed (0 = never).
    // rst_load: assert rst in the first WAIT cycle after this load (0 = never);
    // the task returns with rst high in that case.
    task automatic run_job(input int d0, input int d1, input int d2, input int d3,
                           input int poke_at, input int rst_load);
        int         dly [4];
        int         since, last_load, idle_run;
        logic       started;
        logic [3:0] held_row, held_col;
        int         na [2][2];
        int         nb [2][2];
        dly = '{d0, d1, d2, d3};
        loads = 0; dones = 0; acc_clrs = 0; lat = 0; min_gap = 1000;
        stable_bad = 0; expired = 1;
        since = 0; last_load = -1; idle_run = 0; started = 1'b0;
        held_row = '0; held_col = '0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (bus.busy) started = 1'b1;
            if (bus.acc_clr) begin
                acc_clrs++;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
                    end
            end
            if (bus.load_out) begin
                if (loads < 4) begin
                    rowlog[loads] = bus.row_feed;
                    collog[loads] = bus.col_feed;
                end
                if (last_load >= 0 && (k - last_load) < min_gap) min_gap = k - last_load;
                last_load = k;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        if (j == 0) na[i][j] = int'(bus.row_feed[i*2 +: 2]);
                        else        na[i][j] = ar[i][j-1];
                        if (i == 0) nb[i][j] = int'(bus.col_feed[j*2 +: 2]);
                        else        nb[i][j] = br[i-1][j];
                    end
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        acc[i][j] += na[i][j] * nb[i][j];
                        ar[i][j] = na[i][j];
                        br[i][j] = nb[i][j];
                    end
                loads++;
                held_row = bus.row_feed;
                held_col = bus.col_feed;
                since = 0;
            end else begin
                since++;
                if (bus.busy && loads > 0 && (bus.row_feed !== held_row || bus.col_feed !== held_col))
                    stable_bad++;
            end
            for (int b = 0; b < 4; b++) bus.done_pe_in[b] = (since == dly[b]);
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = k;
            end
            if (rst_load != 0 && loads == rst_load && since == 1) begin
                rst = 1'b1;
                expired = 0;
                return;
            end
            if (poke_at == k) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = 1'b0;
                bus.wr_col  = 1'b0;
                bus.wr_data = 2'd3;
            end
            if (started && !bus.busy) idle_run++;
            else idle_run = 0;
            if (idle_run == 5) begin
                expired = 0;
                return;
            end
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0; bus.done_pe_in = '0;

        // reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_done",    bus.done, 0);
        chk("rst_load",    bus.load_out, 0);
        chk("rst_accclr",  bus.acc_clr, 0);
        chk("rst_row",     bus.row_feed, 0);
        chk("rst_col",     bus.col_feed, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        rst = 1'b0;
        write_ab();

        // nominal job, all PEs done one cycle after load
        run_job(1, 1, 1, 1, 0, 0);
        chk("j1_expired", expired, 0);
        chk("j1_loads",   loads, 4);
        chk("j1_dones",   dones, 1);
        chk("j1_accclr",  acc_clrs, 1);
        chk("j1_latency", lat, 10);
        chk("j1_gap",     min_gap, 2);
        chk("j1_row_t0", rowlog[0], 4'h1); chk("j1_col_t0", collog[0], 4'h2);
        chk("j1_row_t1", rowlog[1], 4'hE); chk("j1_col_t1", collog[1], 4'h5);
        chk("j1_row_t2", rowlog[2], 4'h0); chk("j1_col_t2", collog[2], 4'hC);
        chk("j1_row_t3", rowlog[3], 4'h0); chk("j1_col_t3", collog[3], 4'h0);
        chk("j1_stable", stable_bad, 0);
        check_c("j1", 4, 7, 6, 3);
        chk("j1_busy_after", bus.busy, 0);

        // start + write while busy are ignored
        run_job(1, 1, 1, 1, 4, 0);
        chk("j2_expired", expired, 0);
        chk("j2_dones",   dones, 1);
        chk("j2_loads",   loads, 4);
        check_c("j2", 4, 7, 6, 3);

        // staggered done_pe pulses: bit0 +1, bit1 +2, bit2 +3, bit3 +5
        run_job(1, 2, 3, 5, 0, 0);
        chk("j3_expired", expired, 0);
        chk("j3_loads",   loads, 4);
        chk("j3_dones",   dones, 1);
        chk("j3_gap",     min_gap, 6);
        chk("j3_latency", lat, 26);
        chk("j3_stable",  stable_bad, 0);
        chk("j3_a00_kept", rowlog[0], 4'h1);
        check_c("j3", 4, 7, 6, 3);

        // reset in WAIT of wavefront 2
        run_job(1, 1, 1, 1, 0, 3);
        chk("j4_expired", expired, 0);
        chk("j4_loads",   loads, 3);
        @(negedge clk);
        chk("j4_busy", bus.busy, 0);
        chk("j4_done", bus.done, 0);
        chk("j4_load", bus.load_out, 0);
        chk("j4_row",  bus.row_feed, 0);
        chk("j4_col",  bus.col_feed, 0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("j4_no_done", dones, 0);

        // storage was cleared by reset: product is zero
        run_job(1, 1, 1, 1, 0, 0);
        chk("j5_expired", expired, 0);
        chk("j5_dones",   dones, 1);
        check_c("j5", 0, 0, 0, 0);

        // reload operands and rerun cleanly
        write_ab();
        run_job(1, 1, 1, 1, 0, 0);
        chk("j6_expired", expired, 0);
        chk("j6_dones",   dones, 1);
        chk("j6_latency", lat, 10);
        check_c("j6", 4, 7, 6, 3);

`ifdef FEED_TIMEOUT_EN
        // done_pe never returned: watchdog aborts during the first WAIT
        run_job(100, 100, 100, 100, 0, 0);
        chk("to_expired", expired, 0);
        chk("to_loads",   loads, 1);
        chk("to_dones",   dones, 0);
        chk("to_flag",    bus.timeout_err, 1);
        chk("to_busy",    bus.busy, 0);
`else
        chk("to_tied_low", bus.timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
